// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Accepts an operand on start while idle and converts it over W cycles.
// It then pulses done for one cycle with the result held on bcd/neg.
// With SIGNED=1 the operand is two's complement: bcd is the magnitude and neg is the sign.
module bin2bcd_seq #(
  parameter int W      = 8,
  parameter int DIGITS = 3,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(W);
  localparam logic [W-1:0]  ONE_W   = W'(1);
  localparam logic [CW-1:0] CNT_TOP = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_bin;
  logic [SW-1:0]   r_scratch;
  logic [CW-1:0]   r_cnt;
  logic            r_neg_q;
  logic [SW-1:0]   r_bcd;
  logic            r_neg;
  logic            r_done;

  logic            w_is_neg;
  logic [W-1:0]    w_mag;
  logic [SW-1:0]   w_adj;
  logic [SW-1:0]   w_scr_next;

  // A negative operand is replaced by its magnitude; -2^(W-1) still fits in W unsigned bits.
  assign w_is_neg = (SIGNED != 0) && bin[W-1];
  assign w_mag    = w_is_neg ? (~bin + ONE_W) : bin;

  // Every digit gets its add-3 correction in parallel. A digit never exceeds 9 here, so 4 bits are enough.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign w_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5) ?
                                (r_scratch[4*gi +: 4] + 4'd3) :
                                 r_scratch[4*gi +: 4];
    end
  endgenerate

  // Shift the adjusted scratch left and bring in the next operand MSB.
  // The bit shifted out of the top digit is always zero when DIGITS is sized correctly.
  assign w_scr_next = SW'({w_adj, r_bin[W-1]});

  // Control FSM together with the datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_bin     <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_neg_q   <= 1'b0;
      r_bcd     <= '0;
      r_neg     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_bin     <= w_mag;
            r_neg_q   <= w_is_neg;
            r_scratch <= '0;
            r_cnt     <= CNT_TOP;
            r_state   <= CONV;
          end
        end
        CONV: begin
          r_scratch <= w_scr_next;
          r_bin     <= {r_bin[W-2:0], 1'b0};
          r_cnt     <= r_cnt - CNT_ONE;
          if (r_cnt == '0) begin
            r_bcd   <= w_scr_next;
            r_neg   <= r_neg_q;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready = (r_state == IDLE) && !rst;
  assign done  = r_done;
  assign bcd   = r_bcd;
  assign neg   = r_neg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq. It drives three instances:
//   A = 8-bit unsigned, B = 8-bit signed, C = 16-bit unsigned with 5 digits.
// Expected results come from a decimal model that uses plain division and modulo.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [7:0]  bin_a = '0, bin_b = '0;
  logic [15:0] bin_c = '0;
  logic        ready_a, ready_b, ready_c;
  logic        done_a, done_b, done_c;
  logic [11:0] bcd_a, bcd_b;
  logic [19:0] bcd_c;
  logic        neg_a, neg_b, neg_c;

  int vectors = 0;
  int miscompares = 0;
  int sel = 0;

  logic        done_s, ready_s, neg_s;
  logic [19:0] bcd_s;

  always #5 clk = ~clk;

  bin2bcd_seq #(.W(8), .DIGITS(3), .SIGNED(0)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .bin(bin_a),
    .ready(ready_a), .done(done_a), .bcd(bcd_a), .neg(neg_a));

  bin2bcd_seq #(.W(8), .DIGITS(3), .SIGNED(1)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .bin(bin_b),
    .ready(ready_b), .done(done_b), .bcd(bcd_b), .neg(neg_b));

  bin2bcd_seq #(.W(16), .DIGITS(5), .SIGNED(0)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .bin(bin_c),
    .ready(ready_c), .done(done_c), .bcd(bcd_c), .neg(neg_c));

  assign done_s  = (sel == 0) ? done_a  : (sel == 1) ? done_b  : done_c;
  assign ready_s = (sel == 0) ? ready_a : (sel == 1) ? ready_b : ready_c;
  assign neg_s   = (sel == 0) ? neg_a   : (sel == 1) ? neg_b   : neg_c;
  assign bcd_s   = (sel == 0) ? {8'h00, bcd_a} : (sel == 1) ? {8'h00, bcd_b} : bcd_c;

  // Returns {sign, five BCD digits}. Only instance 1 treats its operand as signed.
  function automatic logic [20:0] ref_model(input int which, input int unsigned v);
    int unsigned mag;
    logic        n;
    logic [19:0] r;
    n   = 1'b0;
    mag = v;
    if (which == 1 && v >= 128) begin
      n   = 1'b1;
      mag = 256 - v;
    end
    r = '0;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    return {n, r};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One conversion on the selected instance. Checks latency, result, done width and the return to ready.
  task automatic convert(input int which, input int unsigned v, input string tag);
    logic [20:0] expv;
    int          cyc;
    int          lat;
    sel = which;
    lat = (which == 2) ? 16 : 8;
    @(negedge clk);
    case (which)
      0:       begin bin_a = 8'(v);  start_a = 1'b1; end
      1:       begin bin_b = 8'(v);  start_b = 1'b1; end
      default: begin bin_c = 16'(v); start_c = 1'b1; end
    endcase
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    check({tag, " ready_low"}, 32'(ready_s), 32'd0);
    cyc = 0;
    while (done_s !== 1'b1 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'(lat));
    expv = ref_model(which, v);
    check({tag, " bcd"}, 32'(bcd_s), 32'(expv[19:0]));
    check({tag, " neg"}, 32'(neg_s), 32'(expv[20]));
    @(posedge clk); #1;
    check({tag, " done_1cyc"}, 32'(done_s), 32'd0);
    check({tag, " ready_back"}, 32'(ready_s), 32'd1);
    $display("conv inst=%0d in=%0d bcd=%0h neg=%0b lat=%0d", which, v, bcd_s, neg_s, cyc);
  endtask

  initial begin : main
    int          cyc;
    int          nacc;
    int          ndone;
    int          last_acc;
    int          seen;
    int unsigned v;
    logic [19:0] last_exp;
    logic [20:0] e;
    int unsigned q[$];

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst ready_a", 32'(ready_a), 32'd0);
    check("rst done_a", 32'(done_a), 32'd0);
    check("rst bcd_a", 32'(bcd_a), 32'd0);
    check("rst neg_b", 32'(neg_b), 32'd0);
    check("rst bcd_c", 32'(bcd_c), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst ready_a", 32'(ready_a), 32'd1);
    check("post_rst ready_c", 32'(ready_c), 32'd1);

    // Unsigned 8-bit corner values
    convert(0, 255, "u8_255");
    convert(0, 0, "u8_0");

    // Exhaustive 0..255 with start held high: results, accept spacing and bcd hold
    sel = 0; v = 0; nacc = 0; ndone = 0; cyc = 0; last_acc = -1;
    last_exp = '0;
    while (ndone < 256 && cyc < 3000) begin
      @(negedge clk);
      if (ready_a && nacc < 256) begin
        bin_a = 8'(v);
        start_a = 1'b1;
        q.push_back(v);
        if (last_acc >= 0) check("exh spacing", 32'(cyc - last_acc), 32'd10);
        last_acc = cyc;
        v++;
        nacc++;
      end
      @(posedge clk); #1;
      cyc++;
      if (done_a) begin
        if (q.size() == 0) begin
          check("exh spurious_done", 32'(done_a), 32'd0);
        end else begin
          e = ref_model(0, q.pop_front());
          last_exp = e[19:0];
          ndone++;
          check("exh bcd", 32'(bcd_a), 32'(last_exp));
          $display("exh in=%0d bcd=%0h", ndone - 1, bcd_a);
        end
      end else begin
        check("exh hold", 32'(bcd_a), 32'(last_exp));
      end
    end
    check("exh count", 32'(ndone), 32'd256);
    @(negedge clk);
    start_a = 1'b0;
    @(posedge clk); #1;

    // start and bin changes during CONV must be ignored
    sel = 0;
    @(negedge clk);
    bin_a = 8'd123; start_a = 1'b1;
    @(posedge clk); #1;
    check("ign ready_low", 32'(ready_a), 32'd0);
    cyc = 0;
    while (done_a !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      start_a = ~start_a;
      bin_a = 8'd7;
      @(posedge clk); #1;
      cyc++;
    end
    check("ign latency", 32'(cyc), 32'd8);
    check("ign bcd", 32'(bcd_a), 32'h123);
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    start_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("ign no_requeue", 32'(ready_a), 32'd1);
    end
    $display("ignored-input conv bcd=%0h", bcd_a);

    // Reset in the middle of a conversion
    @(negedge clk);
    bin_a = 8'd200; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst done", 32'(done_a), 32'd0);
    check("midrst bcd", 32'(bcd_a), 32'd0);
    check("midrst ready_in_rst", 32'(ready_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done_a) seen++;
    end
    check("midrst no_done", 32'(seen), 32'd0);
    check("midrst bcd_after", 32'(bcd_a), 32'd0);
    check("midrst ready_after", 32'(ready_a), 32'd1);
    $display("mid-conversion reset done_seen=%0d bcd=%0h", seen, bcd_a);
    convert(0, 42, "u8_42");

    // Signed 8-bit corners
    convert(1, 8'h80, "s8_80");
    convert(1, 8'hFF, "s8_FF");
    convert(1, 8'h7F, "s8_7F");
    convert(1, 0, "s8_0");

    // 16-bit instance
    convert(2, 65535, "u16_65535");
    convert(2, 10000, "u16_10000");

    // Random operands on all instances
    for (int i = 0; i < 15; i++) begin
      convert(0, $urandom_range(0, 255), "rnd_u8");
      convert(1, $urandom_range(0, 255), "rnd_s8");
      convert(2, $urandom_range(0, 65535), "rnd_u16");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
